// File: rtl/aes_decryption.sv
// aes_decryption: iterative AES-128/256 inverse cipher round engine.
// One inverse round per five cycles: four InvSubBytes words plus one combine.
module aes_decryption (
  input  logic         clk,
  input  logic         reset,
  input  logic         next,
  input  logic         keylen,
  output logic [3:0]   round,
  input  logic [127:0] round_key,
  output logic [31:0]  inv_sboxw,
  input  logic [31:0]  new_inv_sboxw,
  input  logic [127:0] block,
  output logic [127:0] new_block,
  output logic         ready
);

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    SBOX,
    MAIN
  } fsm_t;

  fsm_t         fsm_q, fsm_d;
  logic [127:0] st_q, st_d;
  logic [3:0]   rctr_q, rctr_d;
  logic [1:0]   sctr_q, sctr_d;
  logic [3:0]   nr_q, nr_d;
  logic         rdy_q, rdy_d;

  function automatic logic [7:0] xt(
    input logic [7:0] b
  );
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm9(
    input logic [7:0] b
  );
    return xt(xt(xt(b))) ^ b;
  endfunction

  function automatic logic [7:0] gmb(
    input logic [7:0] b
  );
    return xt(xt(xt(b))) ^ xt(b) ^ b;
  endfunction

  function automatic logic [7:0] gmd(
    input logic [7:0] b
  );
    return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
  endfunction

  function automatic logic [7:0] gme(
    input logic [7:0] b
  );
    return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
  endfunction

  function automatic logic [31:0] imix_w(
    input logic [31:0] w
  );
    logic [7:0] b0, b1, b2, b3;
    b0 = w[31:24];
    b1 = w[23:16];
    b2 = w[15:8];
    b3 = w[7:0];
    return {gme(b0) ^ gmb(b1) ^ gmd(b2) ^ gm9(b3),
            gm9(b0) ^ gme(b1) ^ gmb(b2) ^ gmd(b3),
            gmd(b0) ^ gm9(b1) ^ gme(b2) ^ gmb(b3),
            gmb(b0) ^ gmd(b1) ^ gm9(b2) ^ gme(b3)};
  endfunction

  function automatic logic [127:0] imix(
    input logic [127:0] s
  );
    return {imix_w(s[127:96]), imix_w(s[95:64]),
            imix_w(s[63:32]), imix_w(s[31:0])};
  endfunction

  function automatic logic [127:0] ishift(
    input logic [127:0] s
  );
    logic [31:0] w0, w1, w2, w3;
    w0 = s[127:96];
    w1 = s[95:64];
    w2 = s[63:32];
    w3 = s[31:0];
    return {w0[31:24], w3[23:16], w2[15:8], w1[7:0],
            w1[31:24], w0[23:16], w3[15:8], w2[7:0],
            w2[31:24], w1[23:16], w0[15:8], w3[7:0],
            w3[31:24], w2[23:16], w1[15:8], w0[7:0]};
  endfunction

  // State registers with synchronous reset taking priority
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q  <= IDLE;
      st_q   <= '0;
      rctr_q <= '0;
      sctr_q <= '0;
      nr_q   <= 4'd10;
      rdy_q  <= 1'b1;
    end else begin
      fsm_q  <= fsm_d;
      st_q   <= st_d;
      rctr_q <= rctr_d;
      sctr_q <= sctr_d;
      nr_q   <= nr_d;
      rdy_q  <= rdy_d;
    end
  end

  // Next-state, datapath and S-box port control
  always_comb begin
    fsm_d     = fsm_q;
    st_d      = st_q;
    rctr_d    = rctr_q;
    sctr_d    = sctr_q;
    nr_d      = nr_q;
    rdy_d     = rdy_q;
    inv_sboxw = '0;
    unique case (fsm_q)
      IDLE: begin
        if (next) begin
          nr_d   = keylen ? 4'd14 : 4'd10;
          rctr_d = keylen ? 4'd14 : 4'd10;
          rdy_d  = 1'b0;
          fsm_d  = INIT;
        end
      end
      INIT: begin
        st_d   = ishift(block ^ round_key);
        rctr_d = nr_q - 4'd1;
        sctr_d = 2'd0;
        fsm_d  = SBOX;
      end
      SBOX: begin
        unique case (sctr_q)
          2'd0: begin
            inv_sboxw      = st_q[127:96];
            st_d[127:96]   = new_inv_sboxw;
          end
          2'd1: begin
            inv_sboxw      = st_q[95:64];
            st_d[95:64]    = new_inv_sboxw;
          end
          2'd2: begin
            inv_sboxw      = st_q[63:32];
            st_d[63:32]    = new_inv_sboxw;
          end
          default: begin
            inv_sboxw      = st_q[31:0];
            st_d[31:0]     = new_inv_sboxw;
          end
        endcase
        sctr_d = sctr_q + 2'd1;
        if (sctr_q == 2'd3) fsm_d = MAIN;
      end
      MAIN: begin
        if (rctr_q != 4'd0) begin
          st_d   = ishift(imix(st_q ^ round_key));
          rctr_d = rctr_q - 4'd1;
          sctr_d = 2'd0;
          fsm_d  = SBOX;
        end else begin
          st_d   = st_q ^ round_key;
          rdy_d  = 1'b1;
          fsm_d  = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  assign round     = rctr_q;
  assign new_block = st_q;
  assign ready     = rdy_q;

endmodule

// File: tb/tb_aes_decryption.sv
// tb_aes_decryption: directed FIPS-197 vectors for aes_decryption.
// Provides reference inverse S-box and key-schedule round key memory.
module tb_aes_decryption;

  logic         clk;
  logic         reset;
  logic         next;
  logic         keylen;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic [31:0]  inv_sboxw;
  logic [31:0]  new_inv_sboxw;
  logic [127:0] block;
  logic [127:0] new_block;
  logic         ready;

  aes_decryption dut (
    .clk           (clk),
    .reset         (reset),
    .next          (next),
    .keylen        (keylen),
    .round         (round),
    .round_key     (round_key),
    .inv_sboxw     (inv_sboxw),
    .new_inv_sboxw (new_inv_sboxw),
    .block         (block),
    .new_block     (new_block),
    .ready         (ready)
  );

  logic [7:0]   sbox  [256];
  logic [7:0]   isbox [256];
  logic [127:0] rk    [16];
  int           n_cmp;
  int           n_err;
  bit           toggle;

  localparam logic [127:0] K1   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] K3   =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] KB   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT3  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] CTB  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT13 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] PTB  = 128'h3243f6a8885a308d313198a2e0370734;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign new_inv_sboxw = {isbox[inv_sboxw[31:24]], isbox[inv_sboxw[23:16]],
                          isbox[inv_sboxw[15:8]],  isbox[inv_sboxw[7:0]]};
  assign round_key = rk[round];

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return 8'((x << n) | (x >> (8 - n)));
  endfunction

  task automatic init_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^
          rotl(inv, 4) ^ 8'h63;
      sbox[x]  = s;
      isbox[s] = 8'(x);
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  task automatic expand(input logic [255:0] key, input bit k256);
    logic [31:0] kw [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int          nk, nw;
    nk = k256 ? 8 : 4;
    nw = k256 ? 60 : 44;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) kw[i] = key[255 - 32 * i -: 32];
    for (int i = nk; i < nw; i++) begin
      t = kw[i - 1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (k256 && i % nk == 4) begin
        t = subw(t);
      end
      kw[i] = kw[i - nk] ^ t;
    end
    for (int r = 0; r < 16; r++) begin
      if (4 * r + 3 < nw)
        rk[r] = {kw[4 * r], kw[4 * r + 1], kw[4 * r + 2], kw[4 * r + 3]};
      else
        rk[r] = '0;
    end
  endtask

  // Called at #1 after the accepting edge; returns at first ready cycle.
  task automatic wait_done(input int nr, output int busy,
                           output int rv, output int sv);
    int c;
    c  = 0;
    rv = 0;
    sv = 0;
    while (ready !== 1'b1 && c < 200) begin
      if (round !== 4'(nr - (c + 4) / 5)) rv++;
      if (c % 5 == 0 && inv_sboxw !== 32'h0) sv++;
      if (toggle) begin
        next   = ~next;
        keylen = ~keylen;
      end
      c++;
      @(posedge clk);
      #1;
    end
    if (inv_sboxw !== 32'h0) sv++;
    busy = c;
  endtask

  task automatic run(input string tag, input logic [127:0] ct,
                     input bit kl, input logic [127:0] pt);
    int busy, rv, sv, nr;
    nr     = kl ? 14 : 10;
    block  = ct;
    keylen = kl;
    next   = 1'b1;
    @(posedge clk);
    #1;
    next = 1'b0;
    wait_done(nr, busy, rv, sv);
    next = 1'b0;
    chk({tag, "_pt"}, new_block, pt);
    chk({tag, "_busy"}, 128'(busy), 128'(nr * 5 + 1));
    chk({tag, "_rseq"}, 128'(rv), 128'd0);
    chk({tag, "_sbox0"}, 128'(sv), 128'd0);
  endtask

  initial begin
    int busy, rv, sv, gap;
    n_cmp  = 0;
    n_err  = 0;
    toggle = 1'b0;
    reset  = 1'b1;
    next   = 1'b0;
    keylen = 1'b0;
    block  = '0;
    init_sbox();
    expand({K1, 128'h0}, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 128'(ready), 128'd1);
    chk("rst_block", new_block, 128'd0);
    chk("rst_round", 128'(round), 128'd0);
    chk("rst_sboxw", 128'(inv_sboxw), 128'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    run("c1", CT1, 1'b0, PT13);
    expand(K3, 1'b1);
    run("c3", CT3, 1'b1, PT13);
    expand({KB, 128'h0}, 1'b0);
    run("appb", CTB, 1'b0, PTB);

    expand(K3, 1'b1);
    toggle = 1'b1;
    run("tgl", CT3, 1'b1, PT13);
    toggle = 1'b0;
    keylen = 1'b0;

    expand({K1, 128'h0}, 1'b0);
    block = CT1;
    next  = 1'b1;
    @(posedge clk);
    #1;
    next = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mrst_ready", 128'(ready), 128'd1);
    chk("mrst_block", new_block, 128'd0);
    chk("mrst_round", 128'(round), 128'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    run("c1b", CT1, 1'b0, PT13);

    block = CT1;
    next  = 1'b1;
    @(posedge clk);
    #1;
    wait_done(10, busy, rv, sv);
    chk("b2b1_pt", new_block, PT13);
    chk("b2b1_busy", 128'(busy), 128'd51);
    expand({KB, 128'h0}, 1'b0);
    block = CTB;
    gap   = 0;
    while (ready === 1'b1 && gap < 10) begin
      gap++;
      @(posedge clk);
      #1;
    end
    next = 1'b0;
    chk("b2b_gap", 128'(gap), 128'd1);
    wait_done(10, busy, rv, sv);
    chk("b2b2_pt", new_block, PTB);
    chk("b2b2_busy", 128'(busy), 128'd51);
    chk("b2b2_sbox0", 128'(sv), 128'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_pt", new_block, PTB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/aes_decryption.md
# aes_decryption

Iterative AES-128/AES-256 decipher datapath: the inverse-direction companion to the cipher round engine, turning one 128-bit ciphertext block into plaintext per `next` request. It sits beside the encipher block inside the AES core, sharing the same external key memory (round key selected by `round`). It also uses an external 32-bit inverse S-box, driven over a word-wide request/response port. The block runs one inverse round per 5 cycles (4 InvSubBytes word cycles + 1 round-combine cycle).

## Interface
Parameters: none.

Clock and reset: one clock; reset is synchronous and active-high.

- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- next  input  1  start pulse; sampled only in IDLE.
- keylen  input  1  0 = AES-128 (Nr=10), 1 = AES-256 (Nr=14); latched when `next` is accepted.
- round  output  4  current round index; key memory returns `round_key` combinationally in the same cycle.
- round_key  input  128  round key for index `round`.
- inv_sboxw  output  32  word sent to the external inverse S-box; 0 when not in SBOX.
- new_inv_sboxw  input  32  combinational InvSubBytes of `inv_sboxw`.
- block  input  128  ciphertext; sampled in the INIT cycle only.
- new_block  output  128  state register {w0,w1,w2,w3}, with w0 = bits 127:96. Holds the plaintext when `ready` = 1 after a run.
- ready  output  1  1 = idle/result valid, 0 = busy.

## Operation
- Registers:
  - state words w0..w3 (32b each)
  - round_ctr (4b)
  - sword_ctr (2b)
  - nr (4b, latched round count)
  - ready
  - FSM state
- FSM states and transitions:
  - IDLE: on `next`, set round_ctr = nr = (keylen ? 14 : 10) and ready = 0, then go to INIT. Otherwise hold all state.
  - INIT: compute state = InvShiftRows(block ^ round_key), where `round` = Nr. Then round_ctr -= 1, sword_ctr = 0, go to SBOX.
  - SBOX: drive inv_sboxw = w[sword_ctr] and write new_inv_sboxw into w[sword_ctr]; only that word is written. sword_ctr += 1 (wraps 3→0). When sword_ctr = 3, go to MAIN.
  - MAIN, round_ctr > 0: state = InvShiftRows(InvMixColumns(state ^ round_key)). Then round_ctr -= 1, sword_ctr = 0, go to SBOX.
  - MAIN, round_ctr = 0: state = state ^ round_key, ready = 1, go to IDLE. round_ctr stays 0.
- InvShiftRows, with input words w0..w3 and output words ws0..ws3 (byte 3 = bits 31:24):
  - ws0 = {w0.b3, w3.b2, w2.b1, w1.b0}
  - ws1 = {w1.b3, w0.b2, w3.b1, w2.b0}
  - ws2 = {w2.b3, w1.b2, w0.b1, w3.b0}
  - ws3 = {w3.b3, w2.b2, w1.b1, w0.b0}
- InvMixColumns: applied per word with bytes b0..b3 = bits 31:24..7:0. GF(2^8) uses reduction polynomial 0x11B, and multiplies are built from xtime chains.
  - m0 = 0e·b0 ^ 0b·b1 ^ 0d·b2 ^ 09·b3
  - m1 = 09·b0 ^ 0e·b1 ^ 0b·b2 ^ 0d·b3
  - m2 = 0d·b0 ^ 09·b1 ^ 0e·b2 ^ 0b·b3
  - m3 = 0b·b0 ^ 0d·b1 ^ 09·b2 ^ 0e·b3
- `next` while busy is ignored. `keylen` changes while busy have no effect, because nr was latched at start.
- `round` = round_ctr, so the round keys are consumed in the order Nr, Nr-1, …, 0.

## Timing
- Reset values:
  - w0..w3 = 0, so new_block = 0
  - round_ctr = 0, so round = 0
  - sword_ctr = 0
  - nr = 10
  - ready = 1
  - FSM = IDLE
  - inv_sboxw = 0
- Reset has priority over every other event, including mid-run: on the next edge the block returns to IDLE with ready = 1 and the state cleared.
- `next` sampled at edge E:
  - ready = 0 from E+1.
  - INIT executes at E+1.
  - SBOX runs at E+2..E+5.
  - The first MAIN is at E+6, then each further round takes 5 edges.
- Completion:
  - AES-128: final MAIN at E+51; ready = 1 and plaintext valid after E+51, i.e. 51 cycles busy.
  - AES-256: final MAIN at E+71, i.e. 71 cycles busy.
- A `next` held high in the same cycle that ready returns to 1 is accepted on the following IDLE edge; back-to-back runs therefore have a 1-cycle IDLE gap.
- new_block holds the result until INIT of the next run overwrites it.

## Test plan
The bench supplies a reference inverse S-box and a key-expansion model for `round_key`.
- FIPS-197 C.1, AES-128: key 000102…0f, block 69c4e0d86a7b0430d8cdb78070b4c55a → new_block 00112233445566778899aabbccddeeff. ready low for exactly 51 cycles; round sequence 10,9,…,0.
- FIPS-197 C.3, AES-256: key 000102…1f, block 8ea2b7ca516745bfeafc49904b496089 → 00112233445566778899aabbccddeeff. 71 busy cycles.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, block 3925841d02dc09fbdc118597196a0b32 → 3243f6a8885a308d313198a2e0370734.
- Pulse `next` and toggle `keylen` every cycle mid-run → result and latency unchanged, no restart.
- Assert reset at cycle 20 of a run → after one edge ready = 1, new_block = 0, round = 0. A new C.1 run then passes.
- Back-to-back: hold `next` high across two runs → second result correct; ready high for exactly 1 cycle between runs. inv_sboxw = 0 in all non-SBOX cycles.
